// File: rtl/snake_pkg.sv
// Shared types for the snake game.
//   dir_t      : 2-bit heading encoding used by the command queue and the
//                movement logic (0 right, 1 down, 2 left, 3 up).
//   is_reverse : true when two headings point in opposite directions.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_UP    = 2'd3
  } dir_t;

  // Opposite headings differ only in the upper encoding bit.
  function automatic logic is_reverse(dir_t a, dir_t b);
    return (a ^ b) == 2'b10;
  endfunction

endpackage

// File: rtl/input_debounce.sv
// Conditions one asynchronous level input.
//   clk, rst : clock and synchronous active-low reset
//   din      : raw asynchronous level
//   hold     : when high, a debounced rising edge is swallowed (level still tracks)
//   rise     : registered one-cycle pulse on each debounced rising edge
// Path: 2-FF synchroniser -> stability counter -> rising-edge pulse.
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic hold,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          meta;
  logic          sync;
  logic          level;
  logic [CW-1:0] cnt;
  logic          flip;

  // The level flips on the DEBOUNCE_CYCLES-th consecutive cycle in which the
  // synchronised input disagrees with it.
  assign flip = (sync != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would collapse the synchroniser.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      rise <= flip && sync && !hold;
      if (sync == level) begin
        cnt <= '0;
      end else if (flip) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/dir_cmd_queue.sv
// Turn-command front end for the snake game.
//   clk, rst      : clock, synchronous active-low reset
//   btn_dir[3:0]  : raw buttons (0 up, 1 left, 2 right, 3 down)
//   kb_*          : PS/2 direction levels
//   restart       : game restart level; clears the queue and heading
//   tick          : game-step pulse; releases one queued turn
//   dir           : current heading (dir_t encoding)
//   dir_changed   : pulse when dir takes a newly popped value
//   q_count       : FIFO occupancy
//   req_drop      : pulse when a request edge is discarded
// Requests are filtered against the newest queued heading (or dir when the
// queue is empty) so that duplicates and reversals never enter the queue.
module dir_cmd_queue
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int QUEUE_DEPTH     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [3:0]                     btn_dir,
  input  logic                           kb_up,
  input  logic                           kb_down,
  input  logic                           kb_left,
  input  logic                           kb_right,
  input  logic                           restart,
  input  logic                           tick,
  output logic [1:0]                     dir,
  output logic                           dir_changed,
  output logic [$clog2(QUEUE_DEPTH):0]   q_count,
  output logic                           req_drop
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    raw;
  logic [7:0]    rise;
  dir_t          dir_q;
  dir_t          mem [QUEUE_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] tail_ptr;
  logic [CW-1:0] cnt_q;

  logic req_up, req_down, req_left, req_right;
  logic req_valid, multi, pop, push, reject, drop;
  dir_t req_dir, tail_dir;

  assign raw = {kb_right, kb_left, kb_down, kb_up, btn_dir};

  for (genvar i = 0; i < 8; i++) begin : g_in
    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk  (clk),
      .rst  (rst),
      .din  (raw[i]),
      .hold (restart),
      .rise (rise[i])
    );
  end

  assign tail_ptr = wr_ptr - PW'(1);

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    req_up    = (rise[0] | rise[4]) & ~restart;
    req_left  = (rise[1] | rise[6]) & ~restart;
    req_right = (rise[2] | rise[7]) & ~restart;
    req_down  = (rise[3] | rise[5]) & ~restart;
    req_valid = req_up | req_down | req_left | req_right;
    multi     = $countones({req_up, req_down, req_left, req_right}) > 1;

    req_dir = DIR_RIGHT;
    if (req_up)        req_dir = DIR_UP;
    else if (req_down) req_dir = DIR_DOWN;
    else if (req_left) req_dir = DIR_LEFT;

    tail_dir = (cnt_q != '0) ? mem[tail_ptr] : dir_q;
    pop      = tick && (cnt_q != '0) && !restart;

    // A full queue only refuses when this cycle's pop does not free a slot.
    reject = (req_dir == tail_dir) || is_reverse(req_dir, tail_dir) ||
             ((cnt_q == CW'(QUEUE_DEPTH)) && !pop);
    push   = req_valid && !reject;
    drop   = multi || (req_valid && reject);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dir_q       <= DIR_RIGHT;
      dir_changed <= 1'b0;
      req_drop    <= 1'b0;
      cnt_q       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (restart) begin
      dir_q       <= DIR_RIGHT;
      dir_changed <= 1'b0;
      req_drop    <= 1'b0;
      cnt_q       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      req_drop    <= drop;
      dir_changed <= pop && (mem[rd_ptr] != dir_q);
      if (pop) begin
        dir_q  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: queue storage has no reset; an entry is only read after it has
  // been written, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_dir;
  end

  assign dir     = dir_q;
  assign q_count = cnt_q;

endmodule

// File: tb/tb_dir_cmd_queue.sv
// Scoreboard bench for dir_cmd_queue with DEBOUNCE_CYCLES = 4.
// Stimulus pushes expected output events; a negedge monitor turns every
// req_drop / dir_changed pulse and every q_count change into an event and
// compares it with the front of the queue.
module tb_dir_cmd_queue;
  import snake_pkg::*;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_dir;
  logic       kb_up, kb_down, kb_left, kb_right;
  logic       restart, tick;
  logic [1:0] dir;
  logic       dir_changed;
  logic [2:0] q_count;
  logic       req_drop;

  dir_cmd_queue #(.DEBOUNCE_CYCLES(DEB), .QUEUE_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_dir     (btn_dir),
    .kb_up       (kb_up),
    .kb_down     (kb_down),
    .kb_left     (kb_left),
    .kb_right    (kb_right),
    .restart     (restart),
    .tick        (tick),
    .dir         (dir),
    .dir_changed (dir_changed),
    .q_count     (q_count),
    .req_drop    (req_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_DROP, EV_DIR, EV_CNT} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       val;
    int       cyc;   // -1: any cycle
  } ev_t;

  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       mon_en   = 1'b0;
  logic [2:0] prev_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_kind_e kind, input int val, input int c);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_e kind, input int val);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s=%0d at cycle %0d, expected none", kind.name(), val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || (e.cyc >= 0 && e.cyc != cyc)) begin
        n_fail++;
        $display("FAIL event: got %s=%0d at cycle %0d, expected %s=%0d at cycle %0d",
                 kind.name(), val, cyc, e.kind.name(), e.val, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (req_drop)            observe(EV_DROP, 0);
      if (dir_changed)         observe(EV_DIR, int'(dir));
      if (q_count != prev_cnt) observe(EV_CNT, int'(q_count));
      prev_cnt = q_count;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // idx: 0-3 btn_dir bits, 4 kb_up, 5 kb_down, 6 kb_left, 7 kb_right
  task automatic set_in(input int idx, input logic v);
    case (idx)
      0, 1, 2, 3: btn_dir[idx] = v;
      4:          kb_up        = v;
      5:          kb_down      = v;
      6:          kb_left      = v;
      default:    kb_right     = v;
    endcase
  endtask

  // Press long enough to debounce, then release and let the level fall.
  task automatic press(input int idx);
    set_in(idx, 1'b1);
    step(10);
    set_in(idx, 1'b0);
    step(8);
  endtask

  // Press with tick landing on the same edge as the resulting push.
  task automatic press_tick(input int idx);
    set_in(idx, 1'b1);
    step(6);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(3);
    set_in(idx, 1'b0);
    step(8);
  endtask

  // Request edge reaches the queue 7 edges after the input rises.
  task automatic exp_push(input ev_kind_e kind, input int val);
    expect_ev(kind, val, cyc + 3 + DEB);
  endtask

  task automatic pop_tick(input int new_dir, input int new_cnt);
    expect_ev(EV_DIR, new_dir, cyc + 1);
    expect_ev(EV_CNT, new_cnt, cyc + 1);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(1);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    step(1);
  endtask

  initial begin
    int c;
    rst = 1'b0; btn_dir = '0; kb_up = 1'b0; kb_down = 1'b0;
    kb_left = 1'b0; kb_right = 1'b0; restart = 1'b0; tick = 1'b0;
    step(3);
    check("reset_dir", 32'(dir), 0);
    check("reset_q_count", 32'(q_count), 0);
    check("reset_req_drop", 32'(req_drop), 0);
    check("reset_dir_changed", 32'(dir_changed), 0);
    rst = 1'b1;
    prev_cnt = q_count;
    mon_en = 1'b1;

    // Keyboard up: enqueue after exactly 7 cycles, then tick makes it the heading.
    exp_push(EV_CNT, 1);
    press(4);
    pop_tick(3, 0);
    check("tick_dir_up", 32'(dir), 3);

    // Heading right: left is a reversal; down then left both queue.
    pulse_restart();
    check("restart_dir_right", 32'(dir), 0);
    exp_push(EV_DROP, 0);
    press(1);
    check("reverse_no_enqueue", 32'(q_count), 0);
    exp_push(EV_CNT, 1);
    press(3);
    exp_push(EV_CNT, 2);
    press(6);
    pop_tick(1, 1);
    pop_tick(2, 0);

    // Three-cycle glitch must not produce an edge.
    set_in(0, 1'b1);
    step(3);
    set_in(0, 1'b0);
    step(12);
    check("glitch_no_enqueue", 32'(q_count), 0);

    // Fill with up/left alternating (heading left).
    exp_push(EV_CNT, 1); press(0);
    exp_push(EV_CNT, 2); press(1);
    exp_push(EV_CNT, 3); press(4);
    exp_push(EV_CNT, 4); press(6);
    check("full_count", 32'(q_count), 4);
    exp_push(EV_DROP, 0);
    press(0);
    check("full_drop_count", 32'(q_count), 4);
    exp_push(EV_DIR, 3);
    press_tick(4);
    check("full_tick_push_count", 32'(q_count), 4);
    check("full_tick_dir", 32'(dir), 3);
    pop_tick(2, 3);
    pop_tick(3, 2);
    pop_tick(2, 1);
    pop_tick(3, 0);

    // Up and right in the same cycle: up wins, right dropped.
    pulse_restart();
    c = cyc;
    expect_ev(EV_DROP, 0, c + 3 + DEB);
    expect_ev(EV_CNT, 1, c + 3 + DEB);
    set_in(4, 1'b1);
    set_in(7, 1'b1);
    step(10);
    set_in(4, 1'b0);
    set_in(7, 1'b0);
    step(8);
    // Second up press duplicates the tail.
    exp_push(EV_DROP, 0);
    press(0);
    check("duplicate_count", 32'(q_count), 1);

    // Restart with three queued entries.
    pop_tick(3, 0);
    exp_push(EV_CNT, 1); press(1);
    exp_push(EV_CNT, 2); press(3);
    exp_push(EV_CNT, 3); press(6);
    check("pre_restart_count", 32'(q_count), 3);
    expect_ev(EV_CNT, 0, cyc + 1);
    pulse_restart();
    check("restart_count", 32'(q_count), 0);
    check("restart_dir", 32'(dir), 0);

    // Key rising and held through restart never enqueues.
    set_in(5, 1'b1);
    restart = 1'b1;
    step(12);
    restart = 1'b0;
    step(10);
    set_in(5, 1'b0);
    step(8);
    check("held_key_no_enqueue", 32'(q_count), 0);

    // Tick on an empty queue holds the heading.
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(1);
    check("empty_tick_dir", 32'(dir), 0);

    // Empty queue + tick + push: count 1, heading unchanged.
    exp_push(EV_CNT, 1);
    press_tick(3);
    check("empty_tick_push_count", 32'(q_count), 1);
    check("empty_tick_push_dir", 32'(dir), 0);
    pop_tick(1, 0);
    exp_push(EV_CNT, 1);
    press(1);

    // Reset in the middle of a debounce.
    expect_ev(EV_CNT, 0, -1);
    set_in(7, 1'b1);
    step(4);
    rst = 1'b0;
    set_in(7, 1'b0);
    step(3);
    check("midrst_dir", 32'(dir), 0);
    check("midrst_q_count", 32'(q_count), 0);
    check("midrst_req_drop", 32'(req_drop), 0);
    check("midrst_dir_changed", 32'(dir_changed), 0);
    rst = 1'b1;
    step(12);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
